// File: rtl/tdc_capture_ctrl.sv
// rtl/tdc_capture_ctrl.sv - coarse counter TDC: start/stop interval capture FSM
// Define TDC_AVG_EN to publish the average of every four intervals instead of each one.
module tdc_capture_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start_in,
    input  logic                 stop_in,
    input  logic [7:0]           cfg_ctrl,
    input  logic [7:0]           cfg_timeout,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 timeout_flag,
    output logic                 busy,
    output logic [7:0]           meas_count,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam int LW = CNT_WIDTH + 16;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] result_q;
    logic                 result_valid_q;
    logic                 timeout_flag_q;
    logic [7:0]           meas_count_q;
    logic                 start_prev_q;
    logic                 stop_prev_q;
    logic                 arm_prev_q;

    logic arm, cont, clr, pol;
    logic start_edge, stop_edge, arm_rise;
    logic [LW-1:0] limit_w;
    logic to_hit, sat_hit;
    logic                 fin_d;
    logic                 fin_to_d;
    logic [CNT_WIDTH-1:0] fin_val_d;
    logic                 unused_rsvd;

    assign arm         = cfg_ctrl[0];
    assign cont        = cfg_ctrl[1];
    assign clr         = cfg_ctrl[2];
    assign pol         = cfg_ctrl[3];
    assign unused_rsvd = ^cfg_ctrl[7:4];

    assign start_edge = pol ? (start_prev_q & ~start_in) : (~start_prev_q & start_in);
    assign stop_edge  = pol ? (stop_prev_q & ~stop_in) : (~stop_prev_q & stop_in);
    assign arm_rise   = arm & ~arm_prev_q;

    // A limit that does not fit in the counter can never match; saturation ends the run instead.
    assign limit_w = LW'(cfg_timeout) << 8;
    assign to_hit  = (cfg_timeout != 8'd0) && ((limit_w >> CNT_WIDTH) == '0)
                     && (cnt_q == limit_w[CNT_WIDTH-1:0]);
    assign sat_hit = &cnt_q;

    always_comb begin
        fin_d     = 1'b0;
        fin_to_d  = 1'b0;
        fin_val_d = '0;
        if (state_q == S_ARMED && arm && start_edge && stop_edge) begin
            fin_d = 1'b1;
        end else if (state_q == S_RUN && arm) begin
            if (stop_edge) begin
                fin_d     = 1'b1;
                fin_val_d = cnt_q;
            end else if (to_hit || sat_hit) begin
                fin_d     = 1'b1;
                fin_to_d  = 1'b1;
                fin_val_d = '1;
            end
        end
    end

`ifdef TDC_AVG_EN
    logic [CNT_WIDTH+1:0] acc_q;
    logic [1:0]           batch_q;
    logic                 pub_q;
    logic [CNT_WIDTH+1:0] sum_d;

    assign sum_d = acc_q + (CNT_WIDTH+2)'(fin_val_d);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_flag_q <= 1'b0;
            meas_count_q   <= 8'd0;
            start_prev_q   <= 1'b0;
            stop_prev_q    <= 1'b0;
            arm_prev_q     <= 1'b0;
`ifdef TDC_AVG_EN
            acc_q          <= '0;
            batch_q        <= 2'd0;
            pub_q          <= 1'b0;
`endif
        end else if (ena) begin
            start_prev_q <= start_in;
            stop_prev_q  <= stop_in;
            arm_prev_q   <= arm;
            if (clr) begin
                state_q        <= S_IDLE;
                cnt_q          <= '0;
                result_q       <= '0;
                result_valid_q <= 1'b0;
                timeout_flag_q <= 1'b0;
                meas_count_q   <= 8'd0;
`ifdef TDC_AVG_EN
                acc_q          <= '0;
                batch_q        <= 2'd0;
                pub_q          <= 1'b0;
`endif
            end else if (fin_d) begin
                state_q <= S_DONE;
`ifdef TDC_AVG_EN
                if (fin_to_d) begin
                    result_q       <= '1;
                    timeout_flag_q <= 1'b1;
                    acc_q          <= '0;
                    batch_q        <= 2'd0;
                    pub_q          <= 1'b1;
                end else if (batch_q == 2'd3) begin
                    result_q <= sum_d[CNT_WIDTH+1:2];
                    acc_q    <= '0;
                    batch_q  <= 2'd0;
                    pub_q    <= 1'b1;
                end else begin
                    acc_q   <= sum_d;
                    batch_q <= batch_q + 2'd1;
                    pub_q   <= 1'b0;
                end
`else
                result_q <= fin_val_d;
                if (fin_to_d) begin
                    timeout_flag_q <= 1'b1;
                end
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (arm_rise) begin
                            state_q        <= S_ARMED;
                            timeout_flag_q <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (!arm) begin
                            state_q <= S_IDLE;
                        end else if (start_edge) begin
                            cnt_q   <= CNT_WIDTH'(1);
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!arm) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    S_DONE: begin
`ifdef TDC_AVG_EN
                        if (pub_q) begin
                            result_valid_q <= 1'b1;
                        end
`else
                        result_valid_q <= 1'b1;
`endif
                        meas_count_q <= meas_count_q + 8'd1;
                        state_q      <= (cont && arm) ? S_ARMED : S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout_flag = timeout_flag_q;
    assign meas_count   = meas_count_q;
    assign state_o      = state_q;
    assign busy         = (state_q == S_ARMED) || (state_q == S_RUN);

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// tb/tb_tdc_capture_ctrl.sv - directed scoreboard bench for tdc_capture_ctrl
module tb_tdc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        start_in;
    logic        stop_in;
    logic [7:0]  cfg_ctrl;
    logic [7:0]  cfg_timeout;
    logic [15:0] result;
    logic        result_valid;
    logic        timeout_flag;
    logic        busy;
    logic [7:0]  meas_count;
    logic [1:0]  state_o;

    logic arm_v, cont_v, clr_v, pol_v;
    assign cfg_ctrl = {4'b0000, pol_v, clr_v, cont_v, arm_v};

    always #5 clk = ~clk;

    tdc_capture_ctrl #(.CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .start_in     (start_in),
        .stop_in      (stop_in),
        .cfg_ctrl     (cfg_ctrl),
        .cfg_timeout  (cfg_timeout),
        .result       (result),
        .result_valid (result_valid),
        .timeout_flag (timeout_flag),
        .busy         (busy),
        .meas_count   (meas_count),
        .state_o      (state_o)
    );

    typedef struct {
        logic [15:0] res;
        logic        tf;
        logic [7:0]  mc;
    } exp_t;

    exp_t       sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] mc_model   = 8'd0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_meas(input logic [15:0] r, input logic tf);
        mc_model = mc_model + 8'd1;
        sb.push_back('{r, tf, mc_model});
    endtask

    task automatic arm_set(input logic v);
        arm_v = v;
        cyc(1);
    endtask

    // Start detected at edge T, stop detected at edge T+n.
    task automatic measure(input int n);
        logic a;
        a = ~pol_v;
        start_in = a;
        cyc(1);
        start_in = ~a;
        if (n > 1) cyc(n - 1);
        stop_in = a;
        cyc(1);
        stop_in = ~a;
    endtask

    task automatic start_pulse();
        start_in = ~pol_v;
        cyc(1);
        start_in = pol_v;
    endtask

    task automatic collect(input string tag, input int budget);
        exp_t e;
        int   k;
        k = 0;
        while (state_o !== 2'd3 && k < budget) begin
            cyc(1);
            k++;
        end
        chk({tag, "_done_reached"}, state_o, 2'd3);
        cyc(1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_valid"}, result_valid, 1'b1);
            chk({tag, "_tflag"}, timeout_flag, e.tf);
            chk({tag, "_count"}, meas_count, e.mc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; start_in = 1'b0; stop_in = 1'b0;
        arm_v = 1'b0; cont_v = 1'b0; clr_v = 1'b0; pol_v = 1'b0;
        cfg_timeout = 8'd0;
        cyc(2);
        rst = 1'b0;
        chk("rst_result", result, 16'd0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_tflag", timeout_flag, 1'b0);
        chk("rst_count", meas_count, 8'd0);
        chk("rst_state", state_o, 2'd0);
        chk("rst_busy", busy, 1'b0);

        ena = 1'b0; arm_v = 1'b1;
        cyc(2);
        chk("ena_hold_idle", state_o, 2'd0);
        ena = 1'b1;
        cyc(1);
        chk("armed_state", state_o, 2'd1);
        chk("armed_busy", busy, 1'b1);

        expect_meas(16'd37, 1'b0);
        measure(37);
        collect("single37", 8);
        chk("single_idle", state_o, 2'd0);

        arm_set(1'b0);
        cont_v = 1'b1;
        arm_set(1'b1);
        ena = 1'b0; start_in = 1'b1;
        cyc(2);
        start_in = 1'b0;
        cyc(1);
        ena = 1'b1;
        cyc(2);
        chk("ena_no_edge", state_o, 2'd1);

        for (int i = 1; i <= 3; i++) begin
            expect_meas(16'(i * 10), 1'b0);
            measure(i * 10);
            collect("cont", 8);
            chk("cont_rearm", state_o, 2'd1);
        end

        arm_set(1'b0);
        cont_v = 1'b0; cfg_timeout = 8'd1;
        arm_set(1'b1);
        expect_meas(16'hFFFF, 1'b1);
        start_pulse();
        collect("timeout", 400);
        chk("timeout_idle", state_o, 2'd0);

        arm_set(1'b0);
        arm_set(1'b1);
        chk("tflag_clr_on_arm", timeout_flag, 1'b0);
        start_pulse();
        cyc(5);
        chk("run_state", state_o, 2'd2);
        arm_set(1'b0);
        chk("abort_state", state_o, 2'd0);
        chk("abort_result", result, 16'hFFFF);
        chk("abort_valid", result_valid, 1'b1);
        chk("abort_count", meas_count, mc_model);

        cfg_timeout = 8'd0;
        arm_set(1'b1);
        expect_meas(16'd0, 1'b0);
        start_in = 1'b1; stop_in = 1'b1;
        cyc(1);
        start_in = 1'b0; stop_in = 1'b0;
        collect("same_cycle", 4);

        clr_v = 1'b1;
        cyc(1);
        clr_v = 1'b0;
        mc_model = 8'd0;
        chk("clr_result", result, 16'd0);
        chk("clr_valid", result_valid, 1'b0);
        chk("clr_count", meas_count, 8'd0);
        chk("clr_state", state_o, 2'd0);

        pol_v = 1'b1; start_in = 1'b1; stop_in = 1'b1;
        arm_set(1'b0);
        cont_v = 1'b1;
        arm_set(1'b1);
        expect_meas(16'd15, 1'b0);
        measure(15);
        collect("fall15", 8);
        expect_meas(16'd1, 1'b0);
        measure(1);
        collect("fall1", 8);
        chk("fall_rearm", state_o, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
